// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and derived-width helper
// for the sequential shift-and-add multiplier.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..width inclusive, i.e. $clog2(width+1).
    function automatic int cnt_width(input int width);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < (width + 1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result handshake bundle for the sequential multiplier; the producer
// and consumer side use the master modport, the multiplier the slave modport.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid, signed_mode, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, signed_mode, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_shift_add_multiplier_twos_abs.sv
// Combinational two's-complement magnitude; passes the value through when
// disabled so unsigned operands use the same path.
module twos_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_mag
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Negate only negative signed values; the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        if (i_en && i_val[WIDTH-1]) begin
            o_mag = ~i_val + ONE;
        end else begin
            o_mag = i_val;
        end
    end
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential multiplier: operands are reduced to magnitudes, summed one
// partial product per clock, and the sign is restored on the final iteration.
module seq_shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    seq_shift_add_multiplier_if.slave    bus
);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [2*WIDTH-1:0]   PROD_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_mag_a;
    logic [WIDTH-1:0]       r_mag_b;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic                   r_neg;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_product;
    logic [2*WIDTH-1:0]     w_addend;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic [2*WIDTH-1:0]     w_prod_final;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_release;

    twos_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (bus.a),
        .i_en  (bus.signed_mode),
        .o_mag (w_mag_a)
    );

    twos_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (bus.b),
        .i_en  (bus.signed_mode),
        .o_mag (w_mag_b)
    );

    assign w_accept  = bus.in_valid && r_in_ready;
    assign w_release = r_out_valid && bus.out_ready;
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_addend  = {{WIDTH{1'b0}}, r_mag_a} << r_cnt;

    // Accumulate the current partial product and apply the latched sign on the last one.
    always_comb begin
        w_acc_next   = r_acc;
        w_prod_final = {(2*WIDTH){1'b0}};
        if (r_mag_b[0]) begin
            w_acc_next = r_acc + w_addend;
        end else begin
            w_acc_next = r_acc;
        end
        if (r_neg) begin
            w_prod_final = ~w_acc_next + PROD_ONE;
        end else begin
            w_prod_final = w_acc_next;
        end
    end

    // Next-state decode for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_CALC;
                end
            end
            ST_DONE: begin
                if (w_release) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == ST_IDLE);
            r_out_valid <= (w_state_next == ST_DONE);
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a   <= {WIDTH{1'b0}};
            r_mag_b   <= {WIDTH{1'b0}};
            r_neg     <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_acc     <= {(2*WIDTH){1'b0}};
            r_product <= {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_neg   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_cnt   <= {CNT_W{1'b0}};
                        r_acc   <= {(2*WIDTH){1'b0}};
                    end
                end
                ST_CALC: begin
                    r_acc   <= w_acc_next;
                    r_mag_b <= r_mag_b >> 1;
                    r_cnt   <= r_cnt + CNT_ONE;
                    if (w_last) begin
                        r_product <= w_prod_final;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.product   = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: directed scenarios on WIDTH=4 and WIDTH=8 instances plus
// a randomized run against an integer-arithmetic reference model.
module tb_seq_shift_add_multiplier;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seq_shift_add_multiplier_if #(.WIDTH(4)) bus4 ();
    seq_shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int x;
        int y;
        if (sm) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'(a);
            y = int'(b);
        end
        return 16'(x * y);
    endfunction

    task automatic drive_op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                             output logic [15:0] prod, output int lat, output bit ok);
        int n;
        ok = 1'b0;
        lat = 0;
        prod = 16'd0;
        bus8.a = a;
        bus8.b = b;
        bus8.signed_mode = sm;
        bus8.in_valid = 1'b1;
        n = 0;
        while (bus8.in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 64) begin
            bus8.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.signed_mode = 1'($urandom);
        while (bus8.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = bus8.product;
        ok = (lat < 64);
    endtask

    task automatic drive_op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                             output logic [7:0] prod, output int lat, output bit ok);
        int n;
        ok = 1'b0;
        lat = 0;
        prod = 8'd0;
        bus4.a = a;
        bus4.b = b;
        bus4.signed_mode = sm;
        bus4.in_valid = 1'b1;
        n = 0;
        while (bus4.in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 64) begin
            bus4.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus4.a = 4'($urandom);
        bus4.b = 4'($urandom);
        while (bus4.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = bus4.product;
        ok = (lat < 64);
    endtask

    task automatic release8();
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] st4;
        logic [3:0] st8;
        st4 = {bus4.in_ready, bus4.out_valid, bus4.busy, |bus4.product};
        st8 = {bus8.in_ready, bus8.out_valid, bus8.busy, |bus8.product};
        n_checks++;
        if (st4 !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_w4: {in_ready,out_valid,busy,|product} got %b expected 1000", st4);
        end
        n_checks++;
        if (st8 !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_w8: {in_ready,out_valid,busy,|product} got %b expected 1000", st8);
        end
    endtask

    task automatic test_unsigned4();
        logic [7:0] p;
        int lat;
        bit ok;
        drive_op4(4'd15, 4'd15, 1'b0, p, lat, ok);
        n_checks++;
        if (!ok || p !== 8'hE1) begin
            n_fail++;
            $display("FAIL w4_15x15: product got %h expected e1 (ok=%0d)", p, ok);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL w4_latency: got %0d edges expected 4", lat);
        end
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        n_checks++;
        if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL w4_release: out_valid=%b in_ready=%b expected 0/1", bus4.out_valid, bus4.in_ready);
        end
    endtask

    task automatic test_signed8();
        logic [15:0] p;
        int lat;
        bit ok;
        drive_op8(8'hFD, 8'h07, 1'b1, p, lat, ok);
        n_checks++;
        if (!ok || p !== 16'hFFEB) begin
            n_fail++;
            $display("FAIL s8_m3x7: product got %h expected ffeb", p);
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL s8_latency: got %0d edges expected 8", lat);
        end
        release8();
        drive_op8(8'h80, 8'h80, 1'b1, p, lat, ok);
        n_checks++;
        if (!ok || p !== 16'h4000) begin
            n_fail++;
            $display("FAIL s8_m128sq: product got %h expected 4000", p);
        end
        release8();
        drive_op8(8'h80, 8'h01, 1'b1, p, lat, ok);
        n_checks++;
        if (!ok || p !== 16'hFF80) begin
            n_fail++;
            $display("FAIL s8_m128x1: product got %h expected ff80", p);
        end
        release8();
    endtask

    task automatic test_zero();
        logic [15:0] p;
        int lat;
        bit ok;
        drive_op8(8'hFF, 8'h00, 1'b0, p, lat, ok);
        n_checks++;
        if (!ok || p !== 16'h0000 || lat !== 8) begin
            n_fail++;
            $display("FAIL zero_u: product got %h lat %0d expected 0000 lat 8", p, lat);
        end
        release8();
        drive_op8(8'h00, 8'hFB, 1'b1, p, lat, ok);
        n_checks++;
        if (!ok || p !== 16'h0000 || lat !== 8) begin
            n_fail++;
            $display("FAIL zero_s: product got %h lat %0d expected 0000 lat 8", p, lat);
        end
        release8();
    endtask

    task automatic test_backpressure();
        logic [15:0] p;
        logic [15:0] exp_p;
        int lat;
        bit ok;
        int bad;
        exp_p = ref_mul8(8'h9C, 8'h35, 1'b1);
        drive_op8(8'h9C, 8'h35, 1'b1, p, lat, ok);
        n_checks++;
        if (!ok || p !== exp_p) begin
            n_fail++;
            $display("FAIL bp_product: got %h expected %h", p, exp_p);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus8.in_valid = i[0];
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b1 || bus8.product !== exp_p || bus8.in_ready !== 1'b0) begin
                bad++;
            end
        end
        bus8.in_valid = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles expected 0", bad);
        end
        release8();
        n_checks++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b expected 0/1/0",
                     bus8.out_valid, bus8.in_ready, bus8.busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ignored: busy got %b expected 0", bus8.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat;
        bit ok;
        int phantom;
        bus8.a = 8'hAB;
        bus8.b = 8'h77;
        bus8.signed_mode = 1'b0;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus8.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_busy_before: busy got %b expected 1", bus8.busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_abort: out_valid=%b busy=%b in_ready=%b expected 0/0/1",
                     bus8.out_valid, bus8.busy, bus8.in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        phantom = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b0) phantom++;
        end
        n_checks++;
        if (phantom !== 0) begin
            n_fail++;
            $display("FAIL rm_phantom: out_valid seen %0d cycles expected 0", phantom);
        end
        drive_op8(8'd6, 8'd7, 1'b0, p, lat, ok);
        n_checks++;
        if (!ok || p !== 16'd42 || lat !== 8) begin
            n_fail++;
            $display("FAIL rm_fresh: product got %0d lat %0d expected 42 lat 8", p, lat);
        end
        release8();
    endtask

    task automatic test_random();
        localparam int NOPS = 1000;
        logic [15:0] exp_q[$];
        int  rcv;
        int  sent;
        bit  prod_abort;
        rcv = 0;
        sent = 0;
        prod_abort = 1'b0;
        fork
            begin
                for (int i = 0; i < NOPS; i++) begin
                    int n;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                    bus8.a = 8'($urandom);
                    bus8.b = 8'($urandom);
                    bus8.signed_mode = 1'($urandom);
                    bus8.in_valid = 1'b1;
                    n = 0;
                    while (bus8.in_ready !== 1'b1 && n < 200) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (n >= 200) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rnd_accept_timeout: op %0d never accepted", i);
                        prod_abort = 1'b1;
                        bus8.in_valid = 1'b0;
                        break;
                    end
                    exp_q.push_back(ref_mul8(bus8.a, bus8.b, bus8.signed_mode));
                    sent++;
                    @(posedge clk); #1;
                    bus8.in_valid = 1'b0;
                    bus8.a = 8'($urandom);
                    bus8.b = 8'($urandom);
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (rcv < NOPS && cyc < 60000 && !prod_abort) begin
                    bus8.out_ready = ($urandom_range(0, 3) != 0);
                    if (bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL rnd_extra_output: product %h with no pending input", bus8.product);
                        end else begin
                            logic [15:0] e;
                            e = exp_q.pop_front();
                            if (bus8.product !== e) begin
                                n_fail++;
                                $display("FAIL rnd_product: result %0d got %h expected %h", rcv, bus8.product, e);
                            end
                        end
                        rcv++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                bus8.out_ready = 1'b0;
            end
        join
        n_checks++;
        if (rcv !== NOPS || sent !== NOPS || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rnd_count: sent %0d received %0d pending %0d expected %0d/%0d/0",
                     sent, rcv, exp_q.size(), NOPS, NOPS);
        end
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_quiet: out_valid=%b busy=%b expected 0/0", bus8.out_valid, bus8.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.signed_mode = 1'b0;
        bus4.a = 4'd0;
        bus4.b = 4'd0;
        bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.signed_mode = 1'b0;
        bus8.a = 8'd0;
        bus8.b = 8'd0;
        bus8.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_unsigned4();
        test_signed8();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
